// File: rtl/game_timer.sv
// BCD mm:ss game timer: up/down count, pause/resume, preload, minute ceiling.
// Optional lap capture registers when TIMER_LAP_EN is defined.
module game_timer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int MAX_MIN     = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       clear_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [7:0] load_sec_i,
  input  logic [7:0] load_min_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [1:0] state_o,
  output logic       tick_o,
  output logic       done_o,
  output logic       expire_o
`ifdef TIMER_LAP_EN
  ,
  input  logic       lap_i,
  output logic [7:0] lap_sec_o,
  output logic [7:0] lap_min_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ_HZ - 1);
  localparam logic [7:0] MAX_BCD =
    {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  state_t        state_q, state_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          expire_q, expire_d;
  logic          tick, load_ok, at_max, at_one;
  logic [7:0]    ld_min_val;
  logic [7:0]    sec_up, min_up, sec_dn, min_dn;
`ifdef TIMER_LAP_EN
  logic [7:0]    lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
`endif

  assign tick = (state_q == RUN) && (presc_q == PMAX);
  assign ld_min_val = 8'(load_min_i[7:4]) * 8'd10
                    + 8'(load_min_i[3:0]);
  assign load_ok = (load_sec_i[3:0] <= 4'd9)
                && (load_sec_i[7:4] <= 4'd5)
                && (load_min_i[3:0] <= 4'd9)
                && (load_min_i[7:4] <= 4'd9)
                && (ld_min_val <= 8'(MAX_MIN));
  assign at_max = (sec_q == 8'h59) && (min_q == MAX_BCD);
  assign at_one = (sec_q == 8'h01) && (min_q == 8'h00);

  // Digit-wise carry chain for one second up
  always_comb begin
    sec_up = sec_q;
    min_up = min_q;
    if (sec_q[3:0] != 4'd9) begin
      sec_up[3:0] = sec_q[3:0] + 4'd1;
    end else begin
      sec_up[3:0] = 4'd0;
      if (sec_q[7:4] != 4'd5) begin
        sec_up[7:4] = sec_q[7:4] + 4'd1;
      end else begin
        sec_up[7:4] = 4'd0;
        if (min_q[3:0] != 4'd9) begin
          min_up[3:0] = min_q[3:0] + 4'd1;
        end else begin
          min_up[3:0] = 4'd0;
          min_up[7:4] = min_q[7:4] + 4'd1;
        end
      end
    end
  end

  // Mirror borrow chain for one second down
  always_comb begin
    sec_dn = sec_q;
    min_dn = min_q;
    if (sec_q[3:0] != 4'd0) begin
      sec_dn[3:0] = sec_q[3:0] - 4'd1;
    end else begin
      sec_dn[3:0] = 4'd9;
      if (sec_q[7:4] != 4'd0) begin
        sec_dn[7:4] = sec_q[7:4] - 4'd1;
      end else begin
        sec_dn[7:4] = 4'd5;
        if (min_q[3:0] != 4'd0) begin
          min_dn[3:0] = min_q[3:0] - 4'd1;
        end else begin
          min_dn[3:0] = 4'd9;
          min_dn[7:4] = min_q[7:4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    min_d    = min_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    expire_d = 1'b0;
`ifdef TIMER_LAP_EN
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
      sec_d   = 8'h00;
      min_d   = 8'h00;
      presc_d = '0;
`ifdef TIMER_LAP_EN
      lap_sec_d = 8'h00;
      lap_min_d = 8'h00;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_i) begin
            if (load_ok) begin
              sec_d = load_sec_i;
              min_d = load_min_i;
            end
          end else if (start_i) begin
            dir_d   = dir_i;
            presc_d = '0;
            if (dir_i && sec_q == 8'h00 && min_q == 8'h00) begin
              state_d  = DONE;
              expire_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
`ifdef TIMER_LAP_EN
          if (lap_i) begin
            lap_sec_d = sec_q;
            lap_min_d = min_q;
          end
`endif
          if (tick) begin
            presc_d = '0;
            if (!dir_q) begin
              if (at_max) begin
                state_d  = DONE;
                expire_d = 1'b1;
              end else begin
                sec_d = sec_up;
                min_d = min_up;
              end
            end else begin
              sec_d = sec_dn;
              min_d = min_dn;
              if (at_one) begin
                state_d  = DONE;
                expire_d = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          if (pause_i && state_d == RUN) state_d = PAUSE;
        end
        PAUSE: begin
`ifdef TIMER_LAP_EN
          if (lap_i) begin
            lap_sec_d = sec_q;
            lap_min_d = min_q;
          end
`endif
          if (start_i) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      presc_q  <= '0;
      dir_q    <= 1'b0;
      expire_q <= 1'b0;
`ifdef TIMER_LAP_EN
      lap_sec_q <= 8'h00;
      lap_min_q <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
      expire_q <= expire_d;
`ifdef TIMER_LAP_EN
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
`endif
    end
  end

  assign sec_o    = sec_q;
  assign min_o    = min_q;
  assign state_o  = state_q;
  assign tick_o   = tick & ~clear_i;
  assign done_o   = (state_q == DONE);
  assign expire_o = expire_q;
`ifdef TIMER_LAP_EN
  assign lap_sec_o = lap_sec_q;
  assign lap_min_o = lap_min_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: seconds-total reference model
// predicts output events; a negedge monitor pops and compares them.
module tb_game_timer;

  localparam int F    = 4;
  localparam int MAXM = 10;
  localparam int TMAX = MAXM * 60 + 59;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, pause_i = 1'b0, clear_i = 1'b0;
  logic       dir_i = 1'b0, load_i = 1'b0;
  logic [7:0] load_sec_i = 8'h00, load_min_i = 8'h00;
  logic [7:0] sec_o, min_o;
  logic [1:0] state_o;
  logic       tick_o, done_o, expire_o;
`ifdef TIMER_LAP_EN
  logic       lap_i = 1'b0;
  logic [7:0] lap_sec_o, lap_min_o;
`endif

  game_timer #(.CLK_FREQ_HZ(F), .MAX_MIN(MAXM)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .pause_i(pause_i), .clear_i(clear_i),
    .dir_i(dir_i), .load_i(load_i),
    .load_sec_i(load_sec_i), .load_min_i(load_min_i),
    .sec_o(sec_o), .min_o(min_o), .state_o(state_o),
    .tick_o(tick_o), .done_o(done_o), .expire_o(expire_o)
`ifdef TIMER_LAP_EN
    , .lap_i(lap_i), .lap_sec_o(lap_sec_o), .lap_min_o(lap_min_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] s;
    logic [7:0] m;
    logic       tk;
    logic       ex;
    logic       dn;
    logic [7:0] ls;
    logic [7:0] lm;
  } obs_t;

  typedef struct packed {
    logic [31:0] cyc;
    obs_t        o;
  } ev_t;

  ev_t  q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   m_st, m_t, m_pc, m_lt;
  bit   m_dir, m_ex;
  obs_t m_prev;

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit load_ok(logic [7:0] s, logic [7:0] m);
    return int'(s[3:0]) <= 9 && int'(s[7:4]) <= 5 &&
           int'(m[3:0]) <= 9 && int'(m[7:4]) <= 9 &&
           int'(m[7:4]) * 10 + int'(m[3:0]) <= MAXM;
  endfunction

  function automatic int bcd_val(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = state_o; o.s = sec_o; o.m = min_o;
    o.tk = tick_o; o.ex = expire_o; o.dn = done_o;
`ifdef TIMER_LAP_EN
    o.ls = lap_sec_o; o.lm = lap_min_o;
`else
    o.ls = 8'h00; o.lm = 8'h00;
`endif
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st = 2'(m_st);
    o.s  = bcd(m_t % 60);
    o.m  = bcd(m_t / 60);
    o.tk = (m_st == 1) && (m_pc == F - 1) && !clear_i;
    o.ex = m_ex;
    o.dn = (m_st == 3);
    o.ls = bcd(m_lt % 60);
    o.lm = bcd(m_lt / 60);
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_pc = 0; m_lt = 0;
    m_dir = 0; m_ex = 0;
    m_prev = model_obs();
  endtask

  task automatic model_advance();
    bit ex = 0;
    bit lap = 0;
`ifdef TIMER_LAP_EN
    lap = lap_i;
`endif
    if (clear_i) begin
      m_st = 0; m_t = 0; m_pc = 0; m_lt = 0;
    end else if (m_st == 0) begin
      if (load_i) begin
        if (load_ok(load_sec_i, load_min_i))
          m_t = bcd_val(load_min_i) * 60 + bcd_val(load_sec_i);
      end else if (start_i) begin
        m_dir = dir_i; m_pc = 0;
        if (dir_i && m_t == 0) begin m_st = 3; ex = 1; end
        else m_st = 1;
      end
    end else if (m_st == 1) begin
      if (lap) m_lt = m_t;
      if (m_pc == F - 1) begin
        m_pc = 0;
        if (!m_dir) begin
          if (m_t == TMAX) begin m_st = 3; ex = 1; end
          else m_t++;
        end else begin
          m_t--;
          if (m_t == 0) begin m_st = 3; ex = 1; end
        end
      end else m_pc++;
      if (pause_i && m_st == 1) m_st = 2;
    end else if (m_st == 2) begin
      if (lap) m_lt = m_t;
      if (start_i) m_st = 1;
    end
    m_ex = ex;
  endtask

  task automatic cycle();
    obs_t o = model_obs();
    ev_t  e;
    if (o != m_prev || o.tk || o.ex) begin
      e.cyc = 32'(cyc); e.o = o;
      q.push_back(e);
    end
    m_prev = o;
    model_advance();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_clear();
    clear_i = 1; cycle(); clear_i = 0; cycle();
  endtask

  task automatic do_load(logic [7:0] m, logic [7:0] s);
    load_i = 1; load_min_i = m; load_sec_i = s;
    cycle();
    load_i = 0;
  endtask

  task automatic do_start(bit d);
    dir_i = d; start_i = 1; cycle(); start_i = 0; dir_i = 0;
  endtask

  task automatic reset_checks();
    check("rst_state", 32'(state_o), 0);
    check("rst_sec", 32'(sec_o), 0);
    check("rst_min", 32'(min_o), 0);
    check("rst_tick", 32'(tick_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_expire", 32'(expire_o), 0);
  endtask

  task automatic do_reset();
    start_i = 0; pause_i = 0; clear_i = 0; load_i = 0; dir_i = 0;
`ifdef TIMER_LAP_EN
    lap_i = 0;
`endif
    rst_n = 0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Monitor: compare whenever the DUT's observable outputs change or pulse
  initial begin : monitor
    obs_t p, c;
    ev_t  e;
    p = '0;
    forever begin
      @(negedge clk);
      c = dut_obs();
      if (!rst_n) begin
        p = c;
      end else begin
        if (c != p || c.tk || c.ex) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL ev_unexpected cyc=%0d got %h", cyc, c);
          end else begin
            e = q.pop_front();
            if (e.cyc != 32'(cyc) || e.o !== c) begin
              n_fail++;
              $display("FAIL ev cyc=%0d got %h want cyc=%0d %h",
                       cyc, c, e.cyc, e.o);
            end
          end
        end
        p = c;
      end
    end
  end

  initial begin : driver
    int guard;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    model_reset();
    rst_n = 1;

    // up-count through 01:00
    do_start(0);
    run(240);
    check("up_60s_sec", 32'(sec_o), 32'h00);
    check("up_60s_min", 32'(min_o), 32'h01);
    do_clear();

    // ceiling saturation
    do_load(8'h10, 8'h58);
    do_start(0);
    run(12);
    check("sat_state", 32'(state_o), 3);
    do_clear();

    // down-count and down-start at 00:00
    do_load(8'h00, 8'h02);
    do_start(1);
    run(12);
    do_clear();
    do_start(1);
    run(4);
    do_clear();

    // pause mid-second and resume
    do_start(0);
    guard = 0;
    while (m_pc != 1 && guard < 8) begin cycle(); guard++; end
    pause_i = 1; cycle(); pause_i = 0;
    run(20);
    start_i = 1; cycle(); start_i = 0;
    run(6);
    do_clear();

    // invalid and valid loads, load during RUN, clear on tick
    do_load(8'h00, 8'h6A);
    run(2);
    do_load(8'h11, 8'h00);
    do_load(8'h09, 8'h59);
    do_start(0);
    run(6);
    do_load(8'h00, 8'h00);
    run(3);
    guard = 0;
    while (!(m_st == 1 && m_pc == F - 1) && guard < 8) begin
      cycle(); guard++;
    end
    clear_i = 1; cycle(); clear_i = 0;
    run(3);

`ifdef TIMER_LAP_EN
    do_load(8'h00, 8'h06);
    do_start(0);
    guard = 0;
    while (!(m_t == 7 && m_pc == F - 1) && guard < 16) begin
      cycle(); guard++;
    end
    lap_i = 1; cycle(); lap_i = 0;
    run(2);
    check("lap_sec", 32'(lap_sec_o), 32'h07);
    do_clear();
    check("lap_clr", 32'(lap_sec_o), 32'h00);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clear_i = ($urandom_range(0, 63) == 0);
      load_i  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        load_sec_i = bcd($urandom_range(0, 59));
        load_min_i = bcd($urandom_range(0, MAXM));
      end else begin
        load_sec_i = 8'($urandom);
        load_min_i = 8'($urandom);
      end
      start_i = ($urandom_range(0, 3) == 0);
      pause_i = ($urandom_range(0, 15) == 0);
      dir_i   = 1'($urandom);
`ifdef TIMER_LAP_EN
      lap_i   = ($urandom_range(0, 7) == 0);
`endif
      if (i == 1500) do_reset();
      else cycle();
    end
    start_i = 0; pause_i = 0; clear_i = 0; load_i = 0; dir_i = 0;
`ifdef TIMER_LAP_EN
    lap_i = 0;
`endif
    run(5);
    check("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parameterised BCD game timer, successor to the fixed mm:ss play-time counter.
- Counts up (elapsed time) or down (time-limited games) in mm:ss BCD. Supports pause/resume, preload, a configurable minute ceiling, a done/expire indication and a per-second tick.
- Sits between the game FSM and the seven-segment display driver; the game FSM drives start/pause/clear instead of the block decoding screen state itself.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock cycles per counted second (≥2).
- MAX_MIN, 99, minute ceiling for up-count saturation and load validation (1..99, decimal).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start (IDLE) or resume (PAUSE), level-sampled per cycle
- pause_i  in  1  pause request, honoured in RUN only
- clear_i  in  1  synchronous clear to IDLE, 00:00
- dir_i  in  1  0 = count up, 1 = count down; sampled only on the IDLE→RUN transition
- load_i  in  1  preload strobe, honoured in IDLE only
- load_sec_i  in  8  preload seconds, BCD {tens, units}
- load_min_i  in  8  preload minutes, BCD {tens, units}
- sec_o  out  8  seconds, BCD
- min_o  out  8  minutes, BCD
- state_o  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- tick_o  out  1  one-cycle pulse on each counted second
- done_o  out  1  high while in DONE
- expire_o  out  1  one-cycle pulse on entry to DONE
- lap_i / lap_sec_o / lap_min_o  in 1 / out 8 / out 8  present only with TIMER_LAP_EN

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; sec_o = min_o = 8'h00; prescaler 0.
  - tick_o = done_o = expire_o = 0; stored direction = up.
- Control priority per cycle: clear_i > load_i > start_i/pause_i.
- clear_i: from any state go to IDLE. Set value 00:00, prescaler 0, lap registers 0. Takes effect on the next edge.
- load_i in IDLE:
  - Valid input (units ≤ 9, second tens ≤ 5, minute value ≤ MAX_MIN): registered next cycle.
  - Invalid input: ignored; value unchanged.
  - load_i in RUN, PAUSE or DONE: ignored.
- State transitions:
  - IDLE + start_i → RUN. Latch dir_i; prescaler 0.
  - If down-count is latched and the value is 00:00, go directly to DONE with expire_o pulsed one cycle later.
  - RUN + pause_i → PAUSE. Prescaler and value are held, so a resume continues the partial second.
  - PAUSE + start_i → RUN.
  - DONE leaves only via clear_i or reset.
  - start_i in RUN and pause_i outside RUN have no effect.
- Prescaler:
  - Width $clog2(CLK_FREQ_HZ); advances only in RUN.
  - At CLK_FREQ_HZ-1 it wraps to 0 and asserts tick_o that same cycle. The first tick comes CLK_FREQ_HZ cycles after entering RUN.
- On tick, up-count:
  - Seconds units 9→0 with carry; seconds tens 5→0 with carry; minutes units 9→0 with carry; minutes tens +1. All carries resolve within the same edge.
  - No digit ever holds a non-BCD value or an out-of-range value (e.g. seconds never read 60).
  - At MAX_MIN:59 the tick does not advance the value. State becomes DONE, value held at MAX_MIN:59, expire_o pulses.
- On tick, down-count:
  - Mirror borrow chain: units 0→9, seconds tens 0→5.
  - The tick that produces 00:00 moves to DONE in the same edge, with expire_o high the following cycle for one cycle.
- pause_i coincident with a tick: the tick is applied, then PAUSE.
- clear_i coincident with a tick: clear wins and the tick is discarded.
- Reset mid-operation: all state lost immediately; outputs show reset values.
- done_o = (state == DONE). tick_o is never asserted outside RUN.

Optional Feature:
- Macro TIMER_LAP_EN.
- When defined:
  - Ports lap_i, lap_sec_o and lap_min_o exist.
  - lap_i in RUN or PAUSE copies the current sec_o/min_o into lap_sec_o/lap_min_o on the next edge. If a tick lands in the same cycle, the pre-tick value is captured.
  - lap_i is ignored in IDLE and DONE.
  - Lap registers reset to 00:00 on rst_n and on clear_i.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- CLK_FREQ_HZ=4, up-count: start, run 60 ticks (240 cycles) → sec_o=00, min_o=01. tick_o pulses exactly every 4 cycles. sec_o sequence passes 09→10 and 59→00 with no invalid BCD.
- CLK_FREQ_HZ=4, MAX_MIN=1: load 01:58, start up → after 1 tick reads 01:59. Next tick: value stays 01:59, state_o=11, done_o=1, single-cycle expire_o.
- Down-count: load 00:02, start with dir_i=1 → 00:01 after 4 cycles, 00:00 after 8 with DONE. Start with 00:00 → DONE without any tick_o.
- Pause at prescaler 2, hold 20 cycles, resume → next tick arrives 2 cycles after resume; value is unchanged during pause.
- Loads: load 00:6A (invalid) → value stays 00:00. load_i during RUN → ignored. clear_i coincident with tick → IDLE, 00:00, no tick_o.
- TIMER_LAP_EN: lap_i at 00:07 while a tick lands → lap reads 00:07 and live value 00:08. clear_i → lap 00:00.
